id_ex_forward_reg: RTL and testbench
====================================

ID_EX_FORWARD_REG -- requirements
Module: id_ex_forward_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 inClk  in  1  rising-edge clock.
REQ-003 inRstN  in  1  asynchronous active-low reset.
REQ-004 inStall  in  1  freezes all registers, including the counter.
REQ-005 inFlush  in  1  loads a bubble on the next edge.
REQ-006 inValid  in  1  ID holds a real instruction.
REQ-007 inDataRs, inDataRt, inImm  in  32 each  register-file read data and sign-extended immediate.
REQ-008 inRs, inRt, inRd  in  5 each  source register numbers and final destination (RegDst already applied).
REQ-009 inCtrl  in  8  bit7 RegWrite, bit6 MemRead, bit5 MemWrite, bit4 MemToReg, bit3 AluSrc, bits2:0 AluOp.
REQ-010 inExRegWrite, inExRd  in  1/5  write enable and destination of the instruction now in EX.
REQ-011 inMemRegWrite, inMemRd  in  1/5  write enable and destination of the instruction now in MEM.
REQ-012 outDataRs, outDataRt, outImm, outRs, outRt, outRd, outCtrl, outValid  out  as inputs  registered ID/EX copies.
REQ-013 outForwardA, outForwardB  out  2 each  registered forwarding selects to the EX operand muxes: 00 regfile, 01 WB mux, 10 ALU result.
REQ-014 outHazard  out  1  combinational load-use hazard; the IF/ID stage uses it as a stall request.
REQ-015 outBubbleCnt  out  16  saturating count of inserted bubbles.

Function
REQ-016 Update priority on each rising edge SHALL be: reset, then flush, then stall, then hazard, then capture.
REQ-017 Capture SHALL load every inX into the matching outX with one-cycle latency.
REQ-018 Hold (inStall=1, inFlush=0) SHALL leave every register unchanged, including outForwardA/B and outBubbleCnt.
REQ-019 A bubble (inFlush=1, or outHazard=1 with inStall=0) SHALL set outValid=0 and outCtrl=0.
REQ-020 A bubble SHALL hold the data, register-number and forward-select registers unchanged.
REQ-021 outForwardA on capture SHALL follow these rules, checked in order:
- 2'b10 if inExRegWrite=1, inExRd!=0 and inExRd==inRs;
- else 2'b01 if inMemRegWrite=1, inMemRd!=0 and inMemRd==inRs;
- else 2'b00.
REQ-022 outForwardB SHALL use the same rules as REQ-021 with inRt in place of inRs.
REQ-023 The EX match SHALL take precedence when the EX and MEM destinations are equal.
REQ-024 A captured instruction with inValid=0 SHALL load outCtrl=0 and forward selects 00.
REQ-025 outHazard SHALL be 1 only when all of the following hold:
- outValid=1 and outCtrl[6]=1;
- outRd!=0;
- inValid=1;
- outRd==inRs, or outRd==inRt.
REQ-026 outHazard SHALL be 0 whenever inFlush=1.
REQ-027 outBubbleCnt SHALL increment by 1 on each bubble edge and saturate at 16'hFFFF.
REQ-028 outBubbleCnt SHALL NOT increment when inStall=1 and inFlush=0.
REQ-029 inFlush and inStall asserted together SHALL produce a bubble, and the flush SHALL be counted.
REQ-030 Register $0 SHALL never cause forwarding or a hazard.

Reset
REQ-031 While inRstN=0, all outputs SHALL immediately go to 0; outHazard SHALL therefore be 0.
REQ-032 Reset asserted mid-operation SHALL discard the held instruction.
REQ-033 The first edge after reset release SHALL perform a normal capture.

Verification
REQ-034 The bench SHALL cover capture with forwarding:
- stimulus: inRs=3, inRt=4, inExRegWrite=1, inExRd=3, inMemRegWrite=1, inMemRd=4, inDataRs=32'h11;
- response: next cycle outForwardA=10, outForwardB=01, outDataRs=32'h11, outValid=1.
REQ-035 The bench SHALL cover the EX/MEM tie and $0 cases:
- stimulus: inExRd=inMemRd=5 with both write enables set and inRs=5, then repeat with inRs=0;
- response: outForwardA=10, then 00.
REQ-036 The bench SHALL cover load-use:
- stimulus: load with inCtrl=8'hD0, inRd=7 captured, then inRs=7, inValid=1;
- response: outHazard=1 at once; next edge outValid=0, outCtrl=0, outBubbleCnt=1; outHazard=0 afterwards.
REQ-037 The bench SHALL cover stall and flush priority:
- stimulus: inStall=1 for 3 cycles with changing inputs, then inStall=1 with inFlush=1;
- response: outputs constant for 3 cycles, then outValid=0 and outBubbleCnt incremented.
REQ-038 The bench SHALL cover counter saturation: preload 16'hFFFE, apply 3 flushes -> outBubbleCnt=16'hFFFF and stays there.
REQ-039 The bench SHALL cover asynchronous reset: drive inRstN low mid-cycle while outValid=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_forward_reg_if.sv
// ID/EX pipeline bundle: ID-side instruction fields, EX/MEM writeback info, and
// the registered ID/EX copies with forwarding selects, hazard flag and bubble count.
interface id_ex_forward_reg_if;
  logic        inStall;
  logic        inFlush;
  logic        inValid;
  logic [31:0] inDataRs;
  logic [31:0] inDataRt;
  logic [31:0] inImm;
  logic [4:0]  inRs;
  logic [4:0]  inRt;
  logic [4:0]  inRd;
  logic [7:0]  inCtrl;
  logic        inExRegWrite;
  logic [4:0]  inExRd;
  logic        inMemRegWrite;
  logic [4:0]  inMemRd;

  logic [31:0] outDataRs;
  logic [31:0] outDataRt;
  logic [31:0] outImm;
  logic [4:0]  outRs;
  logic [4:0]  outRt;
  logic [4:0]  outRd;
  logic [7:0]  outCtrl;
  logic        outValid;
  logic [1:0]  outForwardA;
  logic [1:0]  outForwardB;
  logic        outHazard;
  logic [15:0] outBubbleCnt;

  modport master (
    output inStall, inFlush, inValid, inDataRs, inDataRt, inImm, inRs, inRt, inRd,
           inCtrl, inExRegWrite, inExRd, inMemRegWrite, inMemRd,
    input  outDataRs, outDataRt, outImm, outRs, outRt, outRd, outCtrl, outValid,
           outForwardA, outForwardB, outHazard, outBubbleCnt
  );

  modport slave (
    input  inStall, inFlush, inValid, inDataRs, inDataRt, inImm, inRs, inRt, inRd,
           inCtrl, inExRegWrite, inExRd, inMemRegWrite, inMemRd,
    output outDataRs, outDataRt, outImm, outRs, outRt, outRd, outCtrl, outValid,
           outForwardA, outForwardB, outHazard, outBubbleCnt
  );
endinterface

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with EX operand forwarding selects and load-use detection.
// Latency: one cycle for captured fields; outHazard is combinational.
// Backpressure: inStall holds everything; flush or load-use hazard inserts a counted bubble.
module id_ex_forward_reg (
  input logic             inClk,
  input logic             inRstN,
  id_ex_forward_reg_if.slave bus
);
  logic [31:0] dataRsQ, dataRtQ, immQ;
  logic [4:0]  rsQ, rtQ, rdQ;
  logic [7:0]  ctrlQ;
  logic        validQ;
  logic [1:0]  fwdAQ, fwdBQ;
  logic [15:0] bubbleCntQ;
  logic        hazard;
  logic        bubble;

  // EX result is the newer value, so it wins over MEM on a tie; $0 never forwards.
  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (bus.inExRegWrite && bus.inExRd != 5'd0 && bus.inExRd == src)
      return 2'b10;
    else if (bus.inMemRegWrite && bus.inMemRd != 5'd0 && bus.inMemRd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // A load now in EX whose destination feeds the instruction in ID.
  assign hazard = validQ && ctrlQ[6] && (rdQ != 5'd0) && bus.inValid && !bus.inFlush &&
                  ((rdQ == bus.inRs) || (rdQ == bus.inRt));
  assign bubble = bus.inFlush || (!bus.inStall && hazard);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      dataRsQ    <= '0;
      dataRtQ    <= '0;
      immQ       <= '0;
      rsQ        <= '0;
      rtQ        <= '0;
      rdQ        <= '0;
      ctrlQ      <= '0;
      validQ     <= 1'b0;
      fwdAQ      <= 2'b00;
      fwdBQ      <= 2'b00;
      bubbleCntQ <= '0;
    end else if (bubble) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
      if (bubbleCntQ != 16'hFFFF)
        bubbleCntQ <= bubbleCntQ + 16'd1;
    end else if (!bus.inStall) begin
      dataRsQ <= bus.inDataRs;
      dataRtQ <= bus.inDataRt;
      immQ    <= bus.inImm;
      rsQ     <= bus.inRs;
      rtQ     <= bus.inRt;
      rdQ     <= bus.inRd;
      validQ  <= bus.inValid;
      ctrlQ   <= bus.inValid ? bus.inCtrl : 8'h00;
      fwdAQ   <= bus.inValid ? fwdSel(bus.inRs) : 2'b00;
      fwdBQ   <= bus.inValid ? fwdSel(bus.inRt) : 2'b00;
    end
  end

  assign bus.outDataRs    = dataRsQ;
  assign bus.outDataRt    = dataRtQ;
  assign bus.outImm       = immQ;
  assign bus.outRs        = rsQ;
  assign bus.outRt        = rtQ;
  assign bus.outRd        = rdQ;
  assign bus.outCtrl      = ctrlQ;
  assign bus.outValid     = validQ;
  assign bus.outForwardA  = fwdAQ;
  assign bus.outForwardB  = fwdBQ;
  assign bus.outHazard    = hazard;
  assign bus.outBubbleCnt = bubbleCntQ;
endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Randomized and directed bench for id_ex_forward_reg against a behavioural ID/EX model.
module tb_id_ex_forward_reg;
  logic inClk = 1'b0;
  logic inRstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_forward_reg_if bus ();

  id_ex_forward_reg dut (
    .inClk (inClk),
    .inRstN(inRstN),
    .bus   (bus.slave)
  );

  always #5 inClk = ~inClk;

  typedef struct packed {
    logic [31:0] dataRs, dataRt, imm;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic        valid;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
  } st_t;

  st_t m;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Which pipeline stage, if any, produces the operand the ID instruction reads.
  function automatic logic [1:0] refFwd(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (bus.inExRegWrite && bus.inExRd == r) return 2'd2;
    if (bus.inMemRegWrite && bus.inMemRd == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic refHazard();
    logic loadInEx, uses;
    loadInEx = m.valid && m.ctrl[6] && m.rd != 0;
    uses     = bus.inValid && (bus.inRs == m.rd || bus.inRt == m.rd);
    return loadInEx && uses && !bus.inFlush;
  endfunction

  function automatic st_t refNext(input st_t s, input logic haz);
    st_t n = s;
    if (bus.inFlush || (haz && !bus.inStall)) begin
      n.valid = 0;
      n.ctrl  = 0;
      n.cnt   = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 1;
    end else if (!bus.inStall) begin
      n.dataRs = bus.inDataRs; n.dataRt = bus.inDataRt; n.imm = bus.inImm;
      n.rs = bus.inRs; n.rt = bus.inRt; n.rd = bus.inRd;
      n.valid = bus.inValid;
      n.ctrl  = bus.inValid ? bus.inCtrl : 8'h00;
      n.fa    = bus.inValid ? refFwd(bus.inRs) : 2'd0;
      n.fb    = bus.inValid ? refFwd(bus.inRt) : 2'd0;
    end
    return n;
  endfunction

  task automatic compareAll(input string tag);
    checkVal({tag, ".dataRs"}, bus.outDataRs, m.dataRs);
    checkVal({tag, ".dataRt"}, bus.outDataRt, m.dataRt);
    checkVal({tag, ".imm"},    bus.outImm,    m.imm);
    checkVal({tag, ".rs"},     32'(bus.outRs), 32'(m.rs));
    checkVal({tag, ".rt"},     32'(bus.outRt), 32'(m.rt));
    checkVal({tag, ".rd"},     32'(bus.outRd), 32'(m.rd));
    checkVal({tag, ".ctrl"},   32'(bus.outCtrl), 32'(m.ctrl));
    checkVal({tag, ".valid"},  32'(bus.outValid), 32'(m.valid));
    checkVal({tag, ".fwdA"},   32'(bus.outForwardA), 32'(m.fa));
    checkVal({tag, ".fwdB"},   32'(bus.outForwardB), 32'(m.fb));
    checkVal({tag, ".cnt"},    32'(bus.outBubbleCnt), 32'(m.cnt));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    logic h;
    #1;
    h = refHazard();
    checkVal({tag, ".hazard"}, 32'(bus.outHazard), 32'(h));
    m = refNext(m, h);
    @(posedge inClk);
    #1;
    compareAll(tag);
    @(negedge inClk);
  endtask

  task automatic idleIn();
    bus.inStall = 0; bus.inFlush = 0; bus.inValid = 0;
    bus.inDataRs = 0; bus.inDataRt = 0; bus.inImm = 0;
    bus.inRs = 0; bus.inRt = 0; bus.inRd = 0; bus.inCtrl = 0;
    bus.inExRegWrite = 0; bus.inExRd = 0; bus.inMemRegWrite = 0; bus.inMemRd = 0;
  endtask

  task automatic randIn(input int stallPct, input int flushPct);
    bus.inStall  = ($urandom_range(0, 99) < stallPct);
    bus.inFlush  = ($urandom_range(0, 99) < flushPct);
    bus.inValid  = ($urandom_range(0, 3) != 0);
    bus.inDataRs = $urandom; bus.inDataRt = $urandom; bus.inImm = $urandom;
    bus.inRs = 5'($urandom_range(0, 7)); bus.inRt = 5'($urandom_range(0, 7));
    bus.inRd = 5'($urandom_range(0, 7));
    bus.inCtrl = 8'($urandom) | (($urandom_range(0, 2) == 0) ? 8'h40 : 8'h00);
    bus.inExRegWrite  = 1'($urandom); bus.inExRd  = 5'($urandom_range(0, 7));
    bus.inMemRegWrite = 1'($urandom); bus.inMemRd = 5'($urandom_range(0, 7));
  endtask

  task automatic doReset();
    @(negedge inClk);
    inRstN = 0;
    m = '0;
    #2;
    compareAll("rst");
    checkVal("rst.hazard", 32'(bus.outHazard), 32'd0);
    @(negedge inClk);
    inRstN = 1;
  endtask

  initial begin
    st_t snap;
    int  guard;
    m = '0;
    idleIn();
    doReset();

    // Forwarding on capture: EX feeds Rs, MEM feeds Rt.
    bus.inValid = 1; bus.inRs = 3; bus.inRt = 4; bus.inRd = 9; bus.inCtrl = 8'h88;
    bus.inExRegWrite = 1; bus.inExRd = 3; bus.inMemRegWrite = 1; bus.inMemRd = 4;
    bus.inDataRs = 32'h11;
    step("fwd");
    checkVal("fwd.A10", 32'(bus.outForwardA), 32'd2);
    checkVal("fwd.B01", 32'(bus.outForwardB), 32'd1);
    checkVal("fwd.dataRs", bus.outDataRs, 32'h11);
    checkVal("fwd.valid", 32'(bus.outValid), 32'd1);

    // EX/MEM tie goes to EX; register zero never forwards.
    bus.inExRd = 5; bus.inMemRd = 5; bus.inRs = 5; bus.inRt = 1;
    step("tie");
    checkVal("tie.A", 32'(bus.outForwardA), 32'd2);
    bus.inRs = 0; bus.inExRd = 0; bus.inMemRd = 0;
    step("zero");
    checkVal("zero.A", 32'(bus.outForwardA), 32'd0);

    // Load-use: load to r7 in EX, consumer of r7 in ID.
    idleIn();
    doReset();
    bus.inValid = 1; bus.inCtrl = 8'hD0; bus.inRd = 7; bus.inRs = 1; bus.inRt = 2;
    step("load");
    bus.inCtrl = 8'h80; bus.inRd = 8; bus.inRs = 7;
    #1;
    checkVal("lu.hazardNow", 32'(bus.outHazard), 32'd1);
    step("lu");
    checkVal("lu.valid", 32'(bus.outValid), 32'd0);
    checkVal("lu.ctrl", 32'(bus.outCtrl), 32'd0);
    checkVal("lu.cnt", 32'(bus.outBubbleCnt), 32'd1);
    #1;
    checkVal("lu.hazardAfter", 32'(bus.outHazard), 32'd0);
    step("luRetry");

    // Stall three cycles with changing inputs, then stall+flush.
    snap = m;
    for (int i = 0; i < 3; i++) begin
      randIn(0, 0);
      bus.inStall = 1;
      step("stall");
      checkVal("stall.valid", 32'(bus.outValid), 32'(snap.valid));
      checkVal("stall.dataRs", bus.outDataRs, snap.dataRs);
      checkVal("stall.cnt", 32'(bus.outBubbleCnt), 32'(snap.cnt));
    end
    bus.inStall = 1; bus.inFlush = 1;
    step("stflush");
    checkVal("stflush.valid", 32'(bus.outValid), 32'd0);
    checkVal("stflush.cnt", 32'(bus.outBubbleCnt), 32'(snap.cnt + 16'd1));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      randIn(15, 8);
      step("rand");
    end

    // Asynchronous reset while a real instruction sits in ID/EX.
    randIn(0, 0);
    bus.inValid = 1; bus.inExRegWrite = 1; bus.inExRd = 3; bus.inRs = 3;
    step("preRst");
    checkVal("preRst.valid", 32'(bus.outValid), 32'd1);
    #2;
    inRstN = 0;
    m = '0;
    #1;
    compareAll("arst");
    checkVal("arst.hazard", 32'(bus.outHazard), 32'd0);
    @(negedge inClk);
    inRstN = 1;
    idleIn();
    bus.inValid = 1; bus.inRs = 2; bus.inDataRs = 32'hCAFE; bus.inCtrl = 8'h81;
    step("firstCap");
    checkVal("firstCap.dataRs", bus.outDataRs, 32'hCAFE);

    // Bubble counter saturation.
    idleIn();
    bus.inFlush = 1;
    guard = 0;
    while (m.cnt != 16'hFFFE && guard < 70000) begin
      step("fill");
      guard++;
    end
    checkVal("sat.preload", 32'(bus.outBubbleCnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step("sat");
      checkVal("sat.cnt", 32'(bus.outBubbleCnt), 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
